fetch_pc_unit: RTL

Fetch-side PC sequencer: the consumer of the decode-stage branch resolution outputs (`br_taken`, `pc_br`). Owns the architectural PC register, generates PC+4, and drives the IF/ID pipeline register (`pc_out`, `id_valid`) that feeds decode. Implements the single architectural branch delay slot and holds a resolved branch target across decode stalls, so a taken branch redirects fetch exactly once.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_pc_unit_if.sv | 25 ++
 rtl/add.sv | 10 +
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_pc_unit.sv | 99 +++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch sequencer states and fetch constants.
package cpu_pkg;

    localparam int unsigned PC_W_DEF   = 64;
    localparam int unsigned INSN_BYTES = 4;
    localparam logic [PC_W_DEF-1:0] PC_INIT = 64'h0;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch/decode boundary bundle: branch resolution into fetch, IF/ID contents out of fetch.
interface fetch_pc_unit_if #(
    parameter int unsigned PC_W = 64
);
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] pc_if;
    logic [PC_W-1:0] pc_out;
    logic            id_valid;
    logic            in_delay_slot;
    logic            redirect_pending;

    // Decode side drives hazard and branch resolution.
    modport master (
        output stall, br_taken, pc_br,
        input  pc_if, pc_out, id_valid, in_delay_slot, redirect_pending
    );

    // Fetch side owns the PC and the IF/ID register.
    modport slave (
        input  stall, br_taken, pc_br,
        output pc_if, pc_out, id_valid, in_delay_slot, redirect_pending
    );
endinterface

// File: rtl/add.sv
// Generic unsigned adder; carry out is dropped so results wrap modulo 2^W.
module add #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_c
);
    assign sum_c = a_i + b_i;
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: enable-gated capture of decode PC, valid and delay-slot flag.
module if_id_reg #(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            valid_i,
    input  logic            ds_i,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o,
    output logic            ds_o
);
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic            ds_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            ds_q    <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            valid_q <= valid_i;
            ds_q    <= ds_i;
        end
    end

    assign pc_o    = pc_q;
    assign valid_o = valid_q;
    assign ds_o    = ds_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: PC+4 stepping, one architectural delay slot, and a branch
// target held across decode stalls so each taken branch redirects exactly once.
module fetch_pc_unit #(
    parameter int unsigned     PC_W    = 64,
    parameter logic [PC_W-1:0] PC_INIT = PC_W'(cpu_pkg::PC_INIT)
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_pc_unit_if.slave  bus
);
    import cpu_pkg::*;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_if_q, pc_if_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0] pc_plus4_c;
    logic [PC_W-1:0] br_tgt_c;
    logic            br_eff_c;
    logic            ifid_en_c;
    logic            ifid_ds_c;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
    logic            id_ds;

    add #(.W(PC_W)) u_add (
        .a_i   (pc_if_q),
        .b_i   (PC_W'(INSN_BYTES)),
        .sum_c (pc_plus4_c)
    );

    assign br_tgt_c = bus.pc_br & ALIGN_MASK;
    // A branch sitting in a delay slot, or one already captured in PEND, never redirects.
    assign br_eff_c = bus.br_taken & id_valid & ~id_ds & (state_q == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_if_q <= PC_INIT;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_if_q <= pc_if_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_if_d   = pc_if_q;
        pend_d    = pend_q;
        ifid_en_c = 1'b0;
        ifid_ds_c = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    ifid_en_c = 1'b1;
                    if (br_eff_c) begin
                        pc_if_d   = br_tgt_c;
                        ifid_ds_c = 1'b1;
                    end else begin
                        pc_if_d   = pc_plus4_c;
                    end
                end else if (br_eff_c) begin
                    pend_d  = br_tgt_c;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!bus.stall) begin
                    pc_if_d   = pend_q;
                    ifid_en_c = 1'b1;
                    ifid_ds_c = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    if_id_reg #(.PC_W(PC_W)) u_if_id (
        .clk     (clk),
        .rst_n   (reset_n),
        .en_i    (ifid_en_c),
        .pc_i    (pc_if_q),
        .valid_i (1'b1),
        .ds_i    (ifid_ds_c),
        .pc_o    (id_pc),
        .valid_o (id_valid),
        .ds_o    (id_ds)
    );

    assign bus.pc_if            = pc_if_q;
    assign bus.pc_out           = id_pc;
    assign bus.id_valid         = id_valid;
    assign bus.in_delay_slot    = id_ds;
    assign bus.redirect_pending = (state_q == PEND);
endmodule
